// File: rtl/round_countdown_timer_if.sv
// rtl/round_countdown_timer_if.sv - control/status bundle between game FSM and round countdown timer
interface round_countdown_timer_if #(
  parameter int SEC_W = 7
);
  logic             start;
  logic [SEC_W-1:0] load_val;
  logic             pause;
  logic             abort;
  logic [SEC_W-1:0] remaining;
  logic             running;
  logic             paused;
  logic             warn;
  logic             timeout_pulse;
  logic             timeout;

  modport master (
    output start, load_val, pause, abort,
    input  remaining, running, paused, warn, timeout_pulse, timeout
  );

  modport slave (
    input  start, load_val, pause, abort,
    output remaining, running, paused, warn, timeout_pulse, timeout
  );
endinterface

// File: rtl/round_countdown_timer.sv
// rtl/round_countdown_timer.sv - per-round seconds countdown with pause, abort, warning and timeout
module round_countdown_timer #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int SEC_W       = 7,
  parameter int DEFAULT_SEC = 10,
  parameter int WARN_SEC    = 3
) (
  input logic                    clk,
  input logic                    reset,
  round_countdown_timer_if.slave bus
);
  localparam int               PRE_W       = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE     = PRE_W'(1);
  localparam logic [SEC_W-1:0] SEC_DEFAULT = SEC_W'(DEFAULT_SEC);
  localparam logic [SEC_W-1:0] SEC_ONE     = SEC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic             pulse_q, pulse_d;
  logic [SEC_W-1:0] load_eff;
  logic             active;

  // A zero load selects the default round length.
  assign load_eff = (bus.load_val == '0) ? SEC_DEFAULT : bus.load_val;
  assign active   = (state_q == S_RUN) || (state_q == S_PAUSED);

  // State and datapath registers; reset clears everything so every output reads 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      rem_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
    end
  end

  // Next state: start beats abort beats pause; an active timer counts on any edge with pause low,
  // so the resume edge itself counts and each paused cycle costs exactly one cycle of delay.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    rem_d   = rem_q;
    pulse_d = 1'b0;
    if (bus.start) begin
      state_d = bus.pause ? S_PAUSED : S_RUN;
      pre_d   = '0;
      rem_d   = load_eff;
    end else if (active) begin
      if (bus.abort) begin
        state_d = S_IDLE;
        pre_d   = '0;
        rem_d   = '0;
      end else if (bus.pause) begin
        state_d = S_PAUSED;
      end else begin
        state_d = S_RUN;
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (rem_q != '0) begin
            rem_d = rem_q - SEC_ONE;
          end
          if (rem_q == SEC_ONE) begin
            state_d = S_EXPIRED;
            pulse_d = 1'b1;
          end
        end else begin
          pre_d = pre_q + PRE_ONE;
        end
      end
    end
  end

  // Outputs decoded straight from registered state; timeout is sticky because only start/reset leave EXPIRED.
  always_comb begin
    bus.remaining     = rem_q;
    bus.running       = active;
    bus.paused        = (state_q == S_PAUSED);
    bus.warn          = active && (rem_q != '0) && (32'(rem_q) <= $unsigned(WARN_SEC));
    bus.timeout_pulse = pulse_q;
    bus.timeout       = (state_q == S_EXPIRED);
  end
endmodule

// File: tb/tb_round_countdown_timer.sv
// tb/tb_round_countdown_timer.sv - self-checking bench for round_countdown_timer
module tb_round_countdown_timer;
  localparam int TICK_DIV    = 4;
  localparam int SEC_W       = 4;
  localparam int DEFAULT_SEC = 10;
  localparam int WARN_SEC    = 3;

  typedef logic [SEC_W+4:0] vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  round_countdown_timer_if #(.SEC_W(SEC_W)) bus();

  round_countdown_timer #(
    .TICK_DIV(TICK_DIV),
    .SEC_W(SEC_W),
    .DEFAULT_SEC(DEFAULT_SEC),
    .WARN_SEC(WARN_SEC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // reference model: seconds left plus cycles of running progress into the current second
  bit m_on, m_paused, m_exp, m_pulse;
  int m_rem, m_prog;

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic s, logic [SEC_W-1:0] l, logic p, logic a);
    bus.start    = s;
    bus.load_val = l;
    bus.pause    = p;
    bus.abort    = a;
  endtask

  function automatic vec_t obs();
    return {bus.remaining, bus.running, bus.paused, bus.warn, bus.timeout_pulse, bus.timeout};
  endfunction

  function automatic vec_t expv(int rem, bit run, bit pau, bit wrn, bit tp, bit to);
    return {SEC_W'(rem), run, pau, wrn, tp, to};
  endfunction

  function automatic bit wrn_of(int rem);
    return (rem >= 1) && (rem <= WARN_SEC);
  endfunction

  task automatic model_reset();
    m_on = 0; m_paused = 0; m_exp = 0; m_pulse = 0; m_rem = 0; m_prog = 0;
  endtask

  task automatic model_step(bit s, int l, bit p, bit a);
    m_pulse = 0;
    if (s) begin
      m_rem = (l == 0) ? DEFAULT_SEC : l;
      m_prog = 0; m_on = 1; m_exp = 0; m_paused = p;
    end else if (m_on && a) begin
      m_on = 0; m_paused = 0; m_rem = 0; m_prog = 0;
    end else if (m_on) begin
      m_paused = p;
      if (!p) begin
        m_prog++;
        if (m_prog == TICK_DIV) begin
          m_prog = 0;
          m_rem--;
          if (m_rem == 0) begin
            m_on = 0; m_exp = 1; m_pulse = 1;
          end
        end
      end
    end
  endtask

  function automatic vec_t model_vec();
    return expv(m_rem, m_on, m_on && m_paused, m_on && wrn_of(m_rem), m_pulse, m_exp);
  endfunction

  task automatic test_reset();
    drive(1, 5, 1, 0);
    reset = 1'b0;
    tick(2);
    total++;
    if (obs() !== expv(0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL reset_outputs: got %h expected %h", obs(), expv(0, 0, 0, 0, 0, 0));
    end
    drive(0, 0, 0, 0);
    reset = 1'b1;
    tick(3);
    total++;
    if (obs() !== expv(0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL reset_idle: got %h expected %h", obs(), expv(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_default_countdown();
    vec_t e;
    int   rem;
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    for (int t = 0; t <= 44; t++) begin
      if (t < 40) begin
        rem = DEFAULT_SEC - t / TICK_DIV;
        e = expv(rem, 1, 0, wrn_of(rem), 0, 0);
      end else begin
        e = expv(0, 0, 0, 0, t == 40, 1);
      end
      total++;
      if (obs() !== e) begin
        bad++; $display("FAIL default_countdown t=%0d: got %h expected %h", t, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_pause();
    vec_t e;
    int   rem;
    bit   act;
    drive(1, 2, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    for (int t = 0; t <= 15; t++) begin
      act = (t < 13);
      rem = (t < 9) ? 2 : (t < 13) ? 1 : 0;
      e = expv(rem, act, (t >= 2) && (t <= 6), act && wrn_of(rem), t == 13, t >= 13);
      total++;
      if (obs() !== e) begin
        bad++; $display("FAIL pause t=%0d: got %h expected %h", t, obs(), e);
      end
      drive(0, 0, (t + 1 >= 2) && (t + 1 <= 6), 0);
      tick();
    end
  endtask

  task automatic test_abort();
    vec_t e;
    int   rem;
    drive(1, 5, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    for (int t = 0; t <= 12; t++) begin
      if (t < 6) begin
        rem = 5 - t / TICK_DIV;
        e = expv(rem, 1, 0, wrn_of(rem), 0, 0);
      end else begin
        e = expv(0, 0, 0, 0, 0, 0);
      end
      total++;
      if (obs() !== e) begin
        bad++; $display("FAIL abort t=%0d: got %h expected %h", t, obs(), e);
      end
      drive(0, 0, 0, (t == 5) || (t == 7));
      tick();
    end
  endtask

  task automatic test_restart_at_expiry();
    vec_t e;
    int   rem;
    drive(1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    for (int t = 0; t <= 3; t++) begin
      total++;
      if (obs() !== expv(1, 1, 0, 1, 0, 0)) begin
        bad++; $display("FAIL restart_pre t=%0d: got %h expected %h", t, obs(), expv(1, 1, 0, 1, 0, 0));
      end
      if (t == 3) drive(1, 3, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    for (int u = 0; u <= 13; u++) begin
      if (u < 12) begin
        rem = 3 - u / TICK_DIV;
        e = expv(rem, 1, 0, wrn_of(rem), 0, 0);
      end else begin
        e = expv(0, 0, 0, 0, u == 12, 1);
      end
      total++;
      if (obs() !== e) begin
        bad++; $display("FAIL restart_post u=%0d: got %h expected %h", u, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_expired_hold();
    vec_t e;
    int   rem;
    drive(1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick(4);
    for (int t = 0; t < 20; t++) begin
      drive(0, 4'($urandom), 1'($urandom), 1'($urandom));
      tick();
      total++;
      if (obs() !== expv(0, 0, 0, 0, 0, 1)) begin
        bad++; $display("FAIL expired_hold t=%0d: got %h expected %h", t, obs(), expv(0, 0, 0, 0, 0, 1));
      end
    end
    drive(1, 2, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    for (int t = 0; t <= 9; t++) begin
      if (t < 8) begin
        rem = 2 - t / TICK_DIV;
        e = expv(rem, 1, 0, wrn_of(rem), 0, 0);
      end else begin
        e = expv(0, 0, 0, 0, t == 8, 1);
      end
      total++;
      if (obs() !== e) begin
        bad++; $display("FAIL expired_restart t=%0d: got %h expected %h", t, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_count();
    drive(1, 9, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick(12);
    total++;
    if (obs() !== expv(6, 1, 0, 0, 0, 0)) begin
      bad++; $display("FAIL midreset_before: got %h expected %h", obs(), expv(6, 1, 0, 0, 0, 0));
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int t = 0; t < 10; t++) begin
      total++;
      if (obs() !== expv(0, 0, 0, 0, 0, 0)) begin
        bad++; $display("FAIL midreset_idle t=%0d: got %h expected %h", t, obs(), expv(0, 0, 0, 0, 0, 0));
      end
      tick();
    end
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    total++;
    if (obs() !== expv(10, 1, 0, 0, 0, 0)) begin
      bad++; $display("FAIL midreset_restart: got %h expected %h", obs(), expv(10, 1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_random();
    bit s, p, a, r;
    int l;
    p = 0;
    reset = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      s = ($urandom_range(0, 39) == 0);
      l = $urandom_range(0, 6) == 0 ? 0 : $urandom_range(1, 15);
      if ($urandom_range(0, 7) == 0) p = !p;
      a = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 399) == 0);
      drive(s, 4'(l), p, a);
      reset = !r;
      if (r) model_reset();
      else   model_step(s, l, p, a);
      tick();
      reset = 1'b1;
      total++;
      if (obs() !== model_vec()) begin
        bad++; $display("FAIL random c=%0d: got %h expected %h", c, obs(), model_vec());
      end
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0);
    model_reset();
    test_reset();
    test_default_countdown();
    test_pause();
    test_abort();
    test_restart_at_expiry();
    test_expired_hold();
    test_reset_mid_count();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
